// File: rtl/hs_dpath_deser.sv
// Serial-in, parallel-out deserializer: packs RATIO beats (or fewer, closed by s_last)
// into one output word with valid/ready handshakes on both sides.
module hs_dpath_deser #(
  parameter type         DATA_TYPE   = logic,
  parameter DATA_TYPE    RESET_VALUE = 1'b0,
  parameter int unsigned RATIO       = 4
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  DATA_TYPE                         s_data,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output DATA_TYPE [RATIO-1:0]             m_data,
  output logic [$clog2(RATIO+1)-1:0]       m_count
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int MW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  DATA_TYPE [RATIO-1:0] col;
  DATA_TYPE [RATIO-1:0] word_nxt;
  logic [CW-1:0]        cnt;
  logic                 acc;
  logic                 rel;
  logic                 cmpl;

  // aresetn gates s_ready so no beat is offered acceptance while the block is held in reset
  assign s_ready = aresetn & (~m_valid | m_ready);
  assign acc     = s_valid & s_ready;
  assign rel     = m_valid & m_ready;
  assign cmpl    = acc & ((cnt == LAST_IDX) | s_last);

  always_comb begin
    word_nxt = col;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (CW'(i) == cnt) begin
        word_nxt[i] = s_data;
      end else if (CW'(i) > cnt) begin
        word_nxt[i] = RESET_VALUE;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_count <= '0;
      cnt     <= '0;
      for (int i = 0; i < int'(RATIO); i++) begin
        m_data[i] <= RESET_VALUE;
        col[i]    <= RESET_VALUE;
      end
    end else if (cmpl) begin
      m_data  <= word_nxt;
      m_count <= MW'(cnt) + MW'(1);
      m_valid <= 1'b1;
      cnt     <= '0;
      for (int i = 0; i < int'(RATIO); i++) begin
        col[i] <= RESET_VALUE;
      end
    end else begin
      if (rel) begin
        m_valid <= 1'b0;
      end
      if (acc) begin
        col[cnt] <= s_data;
        cnt      <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hs_dpath_deser.sv
// Bench for hs_dpath_deser: directed table/sequences on RATIO 4/2/1 instances plus a
// randomized run of the RATIO=4 instance against a queue-based word model.
module tb_hs_dpath_deser;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic             sv4 = 0, sl4 = 0, mr4 = 0, sr4, mv4;
  logic [7:0]       sd4 = 0;
  logic [3:0][7:0]  md4;
  logic [2:0]       mc4;

  logic             sv2 = 0, sl2 = 0, mr2 = 0, sr2, mv2;
  logic [7:0]       sd2 = 0;
  logic [1:0][7:0]  md2;
  logic [1:0]       mc2;

  logic             sv1 = 0, sl1 = 0, mr1 = 0, sr1, mv1;
  logic [7:0]       sd1 = 0;
  logic [0:0][7:0]  md1;
  logic [0:0]       mc1;

  hs_dpath_deser #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .RATIO(4)) u4 (
    .clk(clk), .aresetn(aresetn), .s_valid(sv4), .s_ready(sr4), .s_data(sd4), .s_last(sl4),
    .m_valid(mv4), .m_ready(mr4), .m_data(md4), .m_count(mc4));

  hs_dpath_deser #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .RATIO(2)) u2 (
    .clk(clk), .aresetn(aresetn), .s_valid(sv2), .s_ready(sr2), .s_data(sd2), .s_last(sl2),
    .m_valid(mv2), .m_ready(mr2), .m_data(md2), .m_count(mc2));

  hs_dpath_deser #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .RATIO(1)) u1 (
    .clk(clk), .aresetn(aresetn), .s_valid(sv1), .s_ready(sr1), .s_data(sd1), .s_last(sl1),
    .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_count(mc1));

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        sl;
    logic        mr;
    logic        emv;
    logic        esr;
    logic [31:0] ed;
    logic [2:0]  ec;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          c;
  } word_t;

  vec_t        tbl[14];
  word_t       ew[$];
  logic [7:0]  cur[$];
  word_t       w;
  logic        rdy;

  initial begin
    // back-to-back full words, then an early close followed by a fresh word
    tbl[0]  = '{1, 8'h01, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[1]  = '{1, 8'h02, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[2]  = '{1, 8'h03, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[3]  = '{1, 8'h04, 0, 1, 1, 1, 32'h04030201, 3'd4};
    tbl[4]  = '{1, 8'h05, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[5]  = '{1, 8'h06, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[6]  = '{1, 8'h07, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[7]  = '{1, 8'h08, 0, 1, 1, 1, 32'h08070605, 3'd4};
    tbl[8]  = '{0, 8'h00, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[9]  = '{1, 8'hA1, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[10] = '{1, 8'hA2, 1, 1, 1, 1, 32'hEEEEA2A1, 3'd2};
    tbl[11] = '{1, 8'hB1, 0, 1, 0, 1, 32'h0, 3'd0};
    tbl[12] = '{1, 8'hB2, 1, 1, 1, 1, 32'hEEEEB2B1, 3'd2};
    tbl[13] = '{0, 8'h00, 0, 1, 0, 1, 32'h0, 3'd0};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_s_ready", sr4, 1'b0);
    chk("rst_hold_m_valid", mv4, 1'b0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_m_valid", mv4, 1'b0);
    chk("rst_s_ready", sr4, 1'b1);
    chk("rst_m_count", mc4, 3'd0);
    chk("rst_m_data", md4, 32'hEEEEEEEE);

    foreach (tbl[r]) begin
      sv4 = tbl[r].sv; sd4 = tbl[r].sd; sl4 = tbl[r].sl; mr4 = tbl[r].mr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_m_valid", r), mv4, tbl[r].emv);
      chk($sformatf("tbl%0d_s_ready", r), sr4, tbl[r].esr);
      if (tbl[r].emv) begin
        chk($sformatf("tbl%0d_m_data", r), md4, tbl[r].ed);
        chk($sformatf("tbl%0d_m_count", r), mc4, tbl[r].ec);
      end
    end
    sv4 = 0; sl4 = 0;

    // backpressure on RATIO=2
    mr2 = 1; sv2 = 1; sd2 = 8'h51;
    @(posedge clk); #1;
    sd2 = 8'h52;
    @(posedge clk); #1;
    chk("bp_first_m_valid", mv2, 1'b1);
    chk("bp_first_m_data", md2, 16'h5251);
    chk("bp_first_m_count", mc2, 2'd2);
    mr2 = 0; sd2 = 8'h53;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_stall_s_ready", sr2, 1'b0);
      chk("bp_stall_m_valid", mv2, 1'b1);
      chk("bp_stall_m_data", md2, 16'h5251);
      chk("bp_stall_m_count", mc2, 2'd2);
      @(posedge clk); #1;
    end
    mr2 = 1;
    #1;
    chk("bp_release_s_ready", sr2, 1'b1);
    @(posedge clk); #1;
    chk("bp_after_release_m_valid", mv2, 1'b0);
    sd2 = 8'h54;
    @(posedge clk); #1;
    chk("bp_resume_m_valid", mv2, 1'b1);
    chk("bp_resume_m_data", md2, 16'h5453);
    sv2 = 0;
    @(posedge clk); #1;

    // RATIO=1: completion and release every cycle
    mr1 = 1; sv1 = 1;
    for (int k = 0; k < 6; k++) begin
      sd1 = 8'h10 + 8'(k);
      @(posedge clk); #1;
      chk($sformatf("r1_m_valid%0d", k), mv1, 1'b1);
      chk($sformatf("r1_m_data%0d", k), md1, 8'h10 + 8'(k));
      chk($sformatf("r1_m_count%0d", k), mc1, 1'b1);
      chk($sformatf("r1_s_ready%0d", k), sr1, 1'b1);
    end
    sv1 = 0;
    @(posedge clk); #1;
    chk("r1_drain_m_valid", mv1, 1'b0);

    // asynchronous reset drops a held word immediately
    sv4 = 1; sd4 = 8'hD1; sl4 = 1; mr4 = 0;
    @(posedge clk); #1;
    chk("ar_held_m_valid", mv4, 1'b1);
    chk("ar_held_m_count", mc4, 3'd1);
    sv4 = 0; sl4 = 0;
    #1 aresetn = 1'b0;
    #1;
    chk("ar_async_m_valid", mv4, 1'b0);
    chk("ar_async_m_count", mc4, 3'd0);
    chk("ar_async_m_data", md4, 32'hEEEEEEEE);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;

    // mid-word reset discards the partial word
    mr4 = 1; sv4 = 1; sd4 = 8'h31;
    @(posedge clk); #1;
    sd4 = 8'h32;
    @(posedge clk); #1;
    sv4 = 0;
    #1 aresetn = 1'b0;
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
    sv4 = 1;
    for (int k = 0; k < 4; k++) begin
      sd4 = 8'h41 + 8'(k);
      @(posedge clk); #1;
      chk($sformatf("mw_m_valid%0d", k), mv4, (k == 3));
    end
    chk("mw_m_data", md4, 32'h44434241);
    chk("mw_m_count", mc4, 3'd4);
    sv4 = 0;
    @(posedge clk); #1;
    chk("mw_drain_m_valid", mv4, 1'b0);

    // randomized traffic against the word model
    for (int cyc = 0; cyc < 400; cyc++) begin
      sv4 = ($urandom_range(0, 3) != 0);
      sd4 = 8'($urandom_range(0, 255));
      sl4 = ($urandom_range(0, 5) == 0);
      mr4 = ($urandom_range(0, 3) != 0);
      #1;
      rdy = (ew.size() == 0) || mr4;
      chk("rnd_s_ready", sr4, rdy);
      chk("rnd_m_valid", mv4, ew.size() != 0);
      if (ew.size() != 0) begin
        chk("rnd_m_data", md4, ew[0].d);
        chk("rnd_m_count", mc4, ew[0].c);
        if (mr4) void'(ew.pop_front());
      end
      if (sv4 && rdy) begin
        cur.push_back(sd4);
        if (cur.size() == 4 || sl4) begin
          w.d = 32'hEEEEEEEE;
          foreach (cur[k]) w.d[8*k +: 8] = cur[k];
          w.c = cur.size();
          ew.push_back(w);
          cur.delete();
        end
      end
      @(posedge clk); #1;
    end
    sv4 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
